// File: rtl/if_id_fetch_queue.sv
// IF/ID decoupling queue: buffers {PC, instr} pairs from fetch and presents the oldest to decode.
// Optional misaligned-PC tagging (AdEL) is enabled by defining IFQ_ADEL_EN.
module if_id_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       fetch_valid,
  input  logic [WIDTH-1:0]           fetch_pc,
  input  logic [WIDTH-1:0]           fetch_instr,
  output logic                       fetch_ready,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [WIDTH-1:0]           id_pc,
  output logic [WIDTH-1:0]           id_instr,
`ifdef IFQ_ADEL_EN
  output logic                       id_adel,
`endif
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [WIDTH-1:0] pc_mem    [DEPTH];
  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [WIDTH-1:0] instr_wr;

  logic full, empty, push, pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Flush suppresses both sides so nothing from the squashed path is consumed or kept.
  assign push = fetch_valid & ~full & ~flush;
  assign pop  = ~empty & id_ready & ~flush;

`ifdef IFQ_ADEL_EN
  logic adel_mem [DEPTH];
  logic adel_wr;

  // A misaligned fetch carries a NOP; ID raises AdEL using id_pc as BadVAddr.
  assign adel_wr  = (fetch_pc[1:0] != 2'b00);
  assign instr_wr = adel_wr ? '0 : fetch_instr;

  always_ff @(posedge clk) begin
    if (push) begin
      adel_mem[wr_ptr_q] <= adel_wr;
    end
  end

  assign id_adel = ~empty & adel_mem[rd_ptr_q];
`else
  assign instr_wr = fetch_instr;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; the head outputs are gated by !empty instead.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= fetch_pc;
      instr_mem[wr_ptr_q] <= instr_wr;
    end
  end

  assign fetch_ready = ~full;
  assign id_valid    = ~empty;
  assign id_pc       = empty ? '0 : pc_mem[rd_ptr_q];
  assign id_instr    = empty ? '0 : instr_mem[rd_ptr_q];
  assign count       = count_q;

endmodule
